// File: rtl/rc_pipe_unit.sv
// rc_pipe_unit: round-robin arbitrated, two-stage route-computation unit for
// the torus/mesh NoC router. Stage A grants one requester and captures its
// destination into S1; stage B computes the productive directions, the hop
// count and the range error, and loads them into the S2 output register.
module rc_pipe_unit #(
    parameter int NUM_REQ  = 17,
    parameter int X_BITS   = 2,
    parameter int Y_BITS   = 2,
    parameter int NODES_X  = 4,
    parameter int NODES_Y  = 4,
    parameter bit TORUS    = 1'b1,
    parameter bit TIE_LFSR = 1'b1,
    parameter int HOP_BITS = $clog2(NODES_X + NODES_Y),
    parameter int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [X_BITS-1:0]                pos_x,
    input  logic [Y_BITS-1:0]                pos_y,
    input  logic [NUM_REQ-1:0]               rc_req,
    input  logic [NUM_REQ*(Y_BITS+X_BITS)-1:0] rc_dest,
    output logic [NUM_REQ-1:0]               rc_gnt,
    output logic                             rc_vld,
    input  logic                             rc_rdy,
    output logic [IDX_BITS-1:0]              rc_idx,
    output logic [3:0]                       rc_route,
    output logic                             rc_local,
    output logic [HOP_BITS-1:0]              rc_hops,
    output logic                             rc_err
);

    localparam int DW = X_BITS + Y_BITS;
    localparam int XW = X_BITS + 1;
    localparam int YW = Y_BITS + 1;
    localparam logic [XW-1:0] NX = XW'(NODES_X);
    localparam logic [YW-1:0] NY = YW'(NODES_Y);
    localparam logic [9:0] SEED_X = 10'h001;
    localparam logic [9:0] SEED_Y = 10'h2A5;

    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    logic                s1_vld_q, s1_vld_d;
    logic [IDX_BITS-1:0] s1_idx_q;
    logic [DW-1:0]       s1_dest_q;
    logic                s2_vld_q, s2_vld_d;
    logic [IDX_BITS-1:0] idx_q;
    logic [3:0]          route_q, route_d;
    logic                local_q, local_d;
    logic [HOP_BITS-1:0] hops_q, hops_d;
    logic                err_q, err_d;
    logic [9:0]          lfsr_x_q, lfsr_y_q;

    logic                win_vld;
    logic [IDX_BITS-1:0] win_idx;
    logic [IDX_BITS:0]   cand;
    logic                s2_load, accept;

    logic [XW-1:0] dx, px, mx, hops_x;
    logic [YW-1:0] dy, py, my, hops_y;
    logic          xp, xn, yp, yn, err_x, err_y, tie_x, tie_y;

    assign s2_load = s1_vld_q && (!s2_vld_q || rc_rdy);
    assign accept  = win_vld && (!s1_vld_q || s2_load);
    assign tie_x   = TIE_LFSR && lfsr_x_q[0];
    assign tie_y   = TIE_LFSR && lfsr_y_q[0];

    assign rc_vld   = s2_vld_q;
    assign rc_idx   = idx_q;
    assign rc_route = route_q;
    assign rc_local = local_q;
    assign rc_hops  = hops_q;
    assign rc_err   = err_q;

    // Round-robin search: first requester at or after ptr, wrapping to 0.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDX_BITS+1)'(i);
            if (cand >= (IDX_BITS+1)'(NUM_REQ))
                cand = cand - (IDX_BITS+1)'(NUM_REQ);
            if (!win_vld && rc_req[cand[IDX_BITS-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_BITS-1:0];
            end
        end
    end

    // Grant, pointer advance and pipeline occupancy next-state.
    always_comb begin
        rc_gnt   = '0;
        ptr_d    = ptr_q;
        s1_vld_d = accept ? 1'b1 : (s2_load ? 1'b0 : s1_vld_q);
        s2_vld_d = s2_load || (s2_vld_q && !rc_rdy);
        if (accept) begin
            if (rst)
                rc_gnt = NUM_REQ'(1) << win_idx;
            ptr_d = (win_idx == IDX_BITS'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // X dimension: direction and hop count from the S1 destination.
    always_comb begin
        dx     = {1'b0, s1_dest_q[X_BITS-1:0]};
        px     = {1'b0, pos_x};
        err_x  = (dx >= NX);
        mx     = '0;
        xp     = 1'b0;
        xn     = 1'b0;
        hops_x = '0;
        if (TORUS) begin
            mx = (dx >= px) ? dx - px : dx - px + NX;
            if (mx != '0) begin
                if ((mx << 1) < NX) begin
                    xp = 1'b1; hops_x = mx;
                end else if ((mx << 1) > NX) begin
                    xn = 1'b1; hops_x = NX - mx;
                end else begin
                    xn = tie_x; xp = !tie_x; hops_x = mx;
                end
            end
        end else if (dx > px) begin
            xp = 1'b1; hops_x = dx - px;
        end else if (dx < px) begin
            xn = 1'b1; hops_x = px - dx;
        end
    end

    // Y dimension: same arithmetic against NODES_Y and the Y tie bit.
    always_comb begin
        dy     = {1'b0, s1_dest_q[DW-1:X_BITS]};
        py     = {1'b0, pos_y};
        err_y  = (dy >= NY);
        my     = '0;
        yp     = 1'b0;
        yn     = 1'b0;
        hops_y = '0;
        if (TORUS) begin
            my = (dy >= py) ? dy - py : dy - py + NY;
            if (my != '0) begin
                if ((my << 1) < NY) begin
                    yp = 1'b1; hops_y = my;
                end else if ((my << 1) > NY) begin
                    yn = 1'b1; hops_y = NY - my;
                end else begin
                    yn = tie_y; yp = !tie_y; hops_y = my;
                end
            end
        end else if (dy > py) begin
            yp = 1'b1; hops_y = dy - py;
        end else if (dy < py) begin
            yn = 1'b1; hops_y = py - dy;
        end
    end

    // Result assembly; an out-of-range destination suppresses every field but err.
    always_comb begin
        err_d   = err_x || err_y;
        route_d = err_d ? 4'b0000 : {yn, yp, xn, xp};
        local_d = !err_d && !(xp || xn || yp || yn);
        hops_d  = err_d ? '0 : HOP_BITS'(hops_x) + HOP_BITS'(hops_y);
    end

    // Pipeline registers, pointer and tie LFSRs (shift on every S2 load).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_dest_q <= '0;
            s2_vld_q  <= 1'b0;
            idx_q     <= '0;
            route_q   <= '0;
            local_q   <= 1'b0;
            hops_q    <= '0;
            err_q     <= 1'b0;
            lfsr_x_q  <= SEED_X;
            lfsr_y_q  <= SEED_Y;
        end else begin
            ptr_q    <= ptr_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            if (accept) begin
                s1_idx_q  <= win_idx;
                s1_dest_q <= rc_dest[win_idx*DW +: DW];
            end
            if (s2_load) begin
                idx_q    <= s1_idx_q;
                route_q  <= route_d;
                local_q  <= local_d;
                hops_q   <= hops_d;
                err_q    <= err_d;
                lfsr_x_q <= {lfsr_x_q[8:0], lfsr_x_q[9] ^ lfsr_x_q[6]};
                lfsr_y_q <= {lfsr_y_q[8:0], lfsr_y_q[9] ^ lfsr_y_q[6]};
            end
        end
    end

endmodule
